tdp_bram_ctrl: RTL and testbench

//  Parametrised true-dual-port block RAM with a single clock.

---
 rtl/tdp_bram_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tdp_bram_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/tdp_bram_ctrl.sv
// True-dual-port single-clock block RAM with byte enables, read-during-write modes, optional output
// register and a post-reset zero-clear sequencer. Optional macro: TDP_BRAM_COLLISION_DETECT_EN.
module tdp_bram_ctrl #(
  parameter int    RAM_WIDTH  = 32,
  parameter int    RAM_DEPTH  = 128,
  parameter int    BYTE_WIDTH = 8,
  parameter string WRITE_MODE = "WRITE_FIRST",
  parameter int    OUT_REG    = 0
) (
  input  logic                             CLK,
  input  logic                             RST,
  output logic                             o_ready,
  input  logic                             i_en_a,
  input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]  i_we_a,
  input  logic [$clog2(RAM_DEPTH)-1:0]     i_addr_a,
  input  logic [RAM_WIDTH-1:0]             i_din_a,
  output logic [RAM_WIDTH-1:0]             o_dout_a,
  output logic                             o_valid_a,
  input  logic                             i_en_b,
  input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]  i_we_b,
  input  logic [$clog2(RAM_DEPTH)-1:0]     i_addr_b,
  input  logic [RAM_WIDTH-1:0]             i_din_b,
  output logic [RAM_WIDTH-1:0]             o_dout_b,
  output logic                             o_valid_b
`ifdef TDP_BRAM_COLLISION_DETECT_EN
  ,output logic                            o_collision
`endif
);
  localparam int NB = RAM_WIDTH / BYTE_WIDTH;
  localparam int AW = $clog2(RAM_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(RAM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
  localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");
  localparam bit MODE_NC = (WRITE_MODE == "NO_CHANGE");

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  function automatic logic [RAM_WIDTH-1:0] f_merge(input logic [RAM_WIDTH-1:0] old_w,
                                                   input logic [RAM_WIDTH-1:0] din,
                                                   input logic [NB-1:0]        we);
    logic [RAM_WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (we[k]) res[k*BYTE_WIDTH +: BYTE_WIDTH] = din[k*BYTE_WIDTH +: BYTE_WIDTH];
      else       res[k*BYTE_WIDTH +: BYTE_WIDTH] = old_w[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
  state_t               r_state;
  logic [AW-1:0]        r_cnt;
  logic                 r_ready;
  logic                 r_v1_a, r_v1_b, r_c1;
  logic [RAM_WIDTH-1:0] r_d1_a, r_d1_b;

  logic                 w_acc_a, w_wr_a, w_inr_a, w_upd_a;
  logic                 w_acc_b, w_wr_b, w_inr_b, w_upd_b;
  logic                 w_same, w_coll;
  logic [RAM_WIDTH-1:0] w_old_a, w_new_a, w_rdat_a, w_old_b, w_new_b, w_rdat_b, w_wdat_a;

  // Request decode, old/merged words and the per-port read-return value
  always_comb begin
    w_acc_a  = r_ready & ~RST & i_en_a;
    w_acc_b  = r_ready & ~RST & i_en_b;
    w_wr_a   = w_acc_a & (|i_we_a);
    w_wr_b   = w_acc_b & (|i_we_b);
    w_inr_a  = ({1'b0, i_addr_a} < DEPTH_L);
    w_inr_b  = ({1'b0, i_addr_b} < DEPTH_L);
    w_old_a  = w_inr_a ? r_mem[i_addr_a] : '0;
    w_old_b  = w_inr_b ? r_mem[i_addr_b] : '0;
    w_new_a  = f_merge(w_old_a, i_din_a, i_we_a);
    w_new_b  = f_merge(w_old_b, i_din_b, i_we_b);
    w_same   = (i_addr_a == i_addr_b);
    w_coll   = w_acc_a & w_acc_b & w_same & (w_wr_a | w_wr_b);
    // A lands on top of B's bytes when both write the same word
    if (w_wr_b && w_same) w_wdat_a = f_merge(w_new_b, i_din_a, i_we_a);
    else                  w_wdat_a = w_new_a;
    if (w_wr_a && MODE_WF && w_inr_a) w_rdat_a = w_new_a;
    else                              w_rdat_a = w_old_a;
    if (w_wr_b && MODE_WF && w_inr_b) w_rdat_b = w_new_b;
    else                              w_rdat_b = w_old_b;
    w_upd_a  = w_acc_a & ~(w_wr_a & MODE_NC);
    w_upd_b  = w_acc_b & ~(w_wr_b & MODE_NC);
  end

  // Storage array: zero-clear while sequencing, otherwise user byte writes
  always_ff @(posedge CLK) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_wr_b && w_inr_b) r_mem[i_addr_b] <= w_new_b;
      if (w_wr_a && w_inr_a) r_mem[i_addr_a] <= w_wdat_a;
    end
  end

  // Clear FSM and first read pipeline stage
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_v1_a  <= 1'b0;
      r_v1_b  <= 1'b0;
      r_c1    <= 1'b0;
      r_d1_a  <= '0;
      r_d1_b  <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == LAST_ADDR) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end
        end
        S_READY: r_state <= S_READY;
        default: r_state <= S_CLEAR;
      endcase
      r_v1_a <= w_acc_a;
      r_v1_b <= w_acc_b;
      r_c1   <= w_coll;
      if (w_upd_a) r_d1_a <= w_rdat_a;
      if (w_upd_b) r_d1_b <= w_rdat_b;
    end
  end

  assign o_ready = r_ready;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                 r_v2_a, r_v2_b, r_c2;
      logic [RAM_WIDTH-1:0] r_d2_a, r_d2_b;
      // Optional output register; data only advances with a valid beat
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_v2_a <= 1'b0;
          r_v2_b <= 1'b0;
          r_c2   <= 1'b0;
          r_d2_a <= '0;
          r_d2_b <= '0;
        end else begin
          r_v2_a <= r_v1_a;
          r_v2_b <= r_v1_b;
          r_c2   <= r_c1;
          if (r_v1_a) r_d2_a <= r_d1_a;
          if (r_v1_b) r_d2_b <= r_d1_b;
        end
      end
      assign o_valid_a = r_v2_a;
      assign o_valid_b = r_v2_b;
      assign o_dout_a  = r_d2_a;
      assign o_dout_b  = r_d2_b;
`ifdef TDP_BRAM_COLLISION_DETECT_EN
      assign o_collision = r_c2;
`else
      logic w_unused_c;
      assign w_unused_c = r_c2;
`endif
    end else begin : g_noreg
      assign o_valid_a = r_v1_a;
      assign o_valid_b = r_v1_b;
      assign o_dout_a  = r_d1_a;
      assign o_dout_b  = r_d1_b;
`ifdef TDP_BRAM_COLLISION_DETECT_EN
      assign o_collision = r_c1;
`else
      logic w_unused_c;
      assign w_unused_c = r_c1;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_tdp_bram_ctrl.sv
// Directed bench for tdp_bram_ctrl: three instances share stimulus (WRITE_FIRST/OUT_REG=0,
// READ_FIRST/OUT_REG=0, NO_CHANGE/OUT_REG=1) and are checked against hand-computed values.
module tb_tdp_bram_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  we_a = 4'h0, we_b = 4'h0;
  logic [6:0]  addr_a = 7'd0, addr_b = 7'd0;
  logic [31:0] din_a = 32'h0, din_b = 32'h0;
  logic        rdy0, rdy1, rdy2, v0a, v0b, v1a, v1b, v2a, v2b;
  logic [31:0] d0a, d0b, d1a, d1b, d2a, d2b;
`ifdef TDP_BRAM_COLLISION_DETECT_EN
  logic        c0, c1, c2;
`endif
  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] acc;
  int vcnt, n;

  always #5 clk = ~clk;

  tdp_bram_ctrl #(.WRITE_MODE("WRITE_FIRST"), .OUT_REG(0)) dut0 (
    .CLK(clk), .RST(rst), .o_ready(rdy0),
    .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a), .o_dout_a(d0a), .o_valid_a(v0a),
    .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b), .o_dout_b(d0b), .o_valid_b(v0b)
`ifdef TDP_BRAM_COLLISION_DETECT_EN
    , .o_collision(c0)
`endif
  );
  tdp_bram_ctrl #(.WRITE_MODE("READ_FIRST"), .OUT_REG(0)) dut1 (
    .CLK(clk), .RST(rst), .o_ready(rdy1),
    .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a), .o_dout_a(d1a), .o_valid_a(v1a),
    .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b), .o_dout_b(d1b), .o_valid_b(v1b)
`ifdef TDP_BRAM_COLLISION_DETECT_EN
    , .o_collision(c1)
`endif
  );
  tdp_bram_ctrl #(.WRITE_MODE("NO_CHANGE"), .OUT_REG(1)) dut2 (
    .CLK(clk), .RST(rst), .o_ready(rdy2),
    .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a), .o_dout_a(d2a), .o_valid_a(v2a),
    .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b), .o_dout_b(d2b), .o_valid_b(v2b)
`ifdef TDP_BRAM_COLLISION_DETECT_EN
    , .o_collision(c2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
  endtask

  task automatic port_a(input logic [3:0] we, input logic [6:0] ad, input logic [31:0] d);
    en_a = 1'b1; we_a = we; addr_a = ad; din_a = d;
  endtask

  task automatic port_b(input logic [3:0] we, input logic [6:0] ad, input logic [31:0] d);
    en_b = 1'b1; we_b = we; addr_b = ad; din_b = d;
  endtask

  initial begin
    logic [31:0] vals [4];
    // reset state
    tick();
    chk("rst_ready", {31'b0, rdy0}, 32'd0);
    chk("rst_valid", {30'b0, v0a, v2a}, 32'd0);
    chk("rst_dout", d0a | d2b, 32'h0);
    // writes attempted during clear, then reset again at count 60
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      port_a(4'hF, 7'(i), 32'hFFFFFFFF);
      tick();
    end
    chk("clr_not_ready", {31'b0, rdy0}, 32'd0);
    chk("clr_no_valid", {31'b0, v0a}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!rdy0 && n < 400) begin
      addr_a = 7'(n);
      tick();
      n++;
    end
    chk("clr_len", 32'(n), 32'd128);
    chk("clr_ready_oreg", {31'b0, rdy2}, 32'd1);
    idle();
    // read every address back
    acc = 32'h0; vcnt = 0;
    for (int i = 0; i < 128; i++) begin
      port_a(4'h0, 7'(i), 32'h0);
      tick();
      acc |= d0a;
      vcnt += int'(v0a);
    end
    idle();
    tick();
    chk("clr_all_zero", acc, 32'h0);
    chk("clr_valids", 32'(vcnt), 32'd128);
    // full write then read @5
    port_a(4'hF, 7'd5, 32'hDEADBEEF);
    tick();
    chk("wf_wr_valid", {31'b0, v0a}, 32'd1);
    chk("wf_wr_ret", d0a, 32'hDEADBEEF);
    chk("rf_wr_ret", d1a, 32'h0);
    port_a(4'h0, 7'd5, 32'h0);
    tick();
    chk("rd_a5", d0a, 32'hDEADBEEF);
    chk("nc_wr_valid", {31'b0, v2a}, 32'd1);
    chk("nc_wr_hold", d2a, 32'h0);
    idle();
    tick();
    chk("oreg_rd", d2a, 32'hDEADBEEF);
    chk("valid_pulse", {31'b0, v0a}, 32'd0);
    chk("dout_hold", d0a, 32'hDEADBEEF);
    // byte-masked write, read through B
    port_a(4'b0101, 7'd5, 32'h11223344);
    tick();
    chk("wf_merge", d0a, 32'hDE22BE44);
    chk("rf_old", d1a, 32'hDEADBEEF);
    idle();
    port_b(4'h0, 7'd5, 32'h0);
    tick();
    chk("b_rd_merge", d0b, 32'hDE22BE44);
    chk("b_rd_valid", {31'b0, v0b}, 32'd1);
    idle();
    // read-during-write mode sweep @7
    port_a(4'hF, 7'd7, 32'hAAAAAAAA);
    tick();
    idle();
    tick();
    port_a(4'hF, 7'd7, 32'h55555555);
    tick();
    chk("wf_sweep", d0a, 32'h55555555);
    chk("rf_sweep", d1a, 32'hAAAAAAAA);
    idle();
    tick();
    chk("nc_sweep", d2a, 32'hDEADBEEF);
    chk("nc_sweep_valid", {31'b0, v2a}, 32'd1);
    // dual write collision @9
    port_a(4'b0011, 7'd9, 32'h000000AA);
    port_b(4'b1111, 7'd9, 32'hBBBBBBBB);
    tick();
`ifdef TDP_BRAM_COLLISION_DETECT_EN
    chk("coll_flag", {31'b0, c0}, 32'd1);
`endif
    idle();
    port_a(4'h0, 7'd9, 32'h0);
    port_b(4'h0, 7'd9, 32'h0);
    tick();
    chk("coll_merge_a", d0a, 32'hBBBB00AA);
    chk("coll_merge_b", d0b, 32'hBBBB00AA);
`ifdef TDP_BRAM_COLLISION_DETECT_EN
    chk("coll_rd_noflag", {31'b0, c0}, 32'd0);
`endif
    // write/read collision @10: reader sees old data
    port_a(4'hF, 7'd10, 32'h12345678);
    port_b(4'h0, 7'd10, 32'h0);
    tick();
    chk("coll_rd_old", d0b, 32'h0);
    idle();
    port_b(4'h0, 7'd10, 32'h0);
    tick();
    chk("coll_rd_new", d0b, 32'h12345678);
    idle();
    // back-to-back writes @0..3 then a 4-beat read burst
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'hC0DE0000 + 32'(i * 17);
      port_a(4'hF, 7'(i), vals[i]);
      tick();
    end
    idle();
    tick();
    tick();
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) port_a(4'h0, 7'(k - 1), 32'h0);
      else        idle();
      tick();
      chk($sformatf("burst_v2_%0d", k), {31'b0, v2a}, (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 5) chk($sformatf("burst_d2_%0d", k), d2a, vals[k - 2]);
      if (k <= 4) chk($sformatf("burst_d0_%0d", k), d0a, vals[k - 1]);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
